// File: rtl/shiftreg_tx_arbiter_if.sv
// Handshake and serial-output bundle between the word producers and the
// two-requester shift-channel sequencer.
interface shiftreg_tx_arbiter_if #(
  parameter int unsigned W = 8
) ();
  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         sh_out;
  logic         sh_en;
  logic         sh_frame;
  logic         grant;
  logic         busy;
  logic         done;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, sh_out, sh_en, sh_frame, grant, busy, done
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, sh_out, sh_en, sh_frame, grant, busy, done
  );
endinterface

// File: rtl/shiftreg_tx_arbiter.sv
// Round-robin arbiter for two word sources feeding an MSB-first serial
// shifter with programmable bit period and inter-frame gap.
module shiftreg_tx_arbiter #(
  parameter int unsigned W   = 8,
  parameter int unsigned DIV = 4,
  parameter int unsigned GAP = 2
) (
  input logic                  clk,
  input logic                  rst,
  shiftreg_tx_arbiter_if.slave bus
);
  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = $clog2(W);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_q, grant_d;
  logic          done_q, done_d;
  logic          winner;
  logic          ready0, ready1;
  logic          in_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    done_d       = 1'b0;
    ready0       = 1'b0;
    ready1       = 1'b0;
    // Contention goes to whoever did not win last; a lone requester always wins.
    winner       = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

    unique case (state_q)
      S_IDLE: begin
        if (!rst && (bus.req0_valid || bus.req1_valid)) begin
          ready0       = ~winner;
          ready1       = winner;
          shreg_d      = winner ? bus.req1_data : bus.req0_data;
          grant_d      = winner;
          last_grant_d = winner;
          div_cnt_d    = '0;
          bit_cnt_d    = '0;
          state_d      = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          shreg_d   = {shreg_q[W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            done_d    = 1'b1;
            gap_cnt_d = '0;
            state_d   = (GAP > 0) ? S_GAP : S_IDLE;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_shift       = (state_q == S_SHIFT);
  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.sh_frame   = in_shift;
  assign bus.sh_out     = in_shift & shreg_q[W-1];
  assign bus.sh_en      = in_shift & (div_cnt_q == '0);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_shiftreg_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected frames, per-DUT monitors check
// every serial frame, handshake and flag as the DUT produces it.
module tb_shiftreg_tx_arbiter;
  localparam int W = 8;

  typedef struct {
    int         grant;
    logic [7:0] data;
    bit         gapchk;
    int         abort_at;
  } exp_t;

  typedef struct packed {
    logic r0, r1, out, en, frame, grant, busy, done;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  shiftreg_tx_arbiter_if #(.W(8)) bi0 ();
  shiftreg_tx_arbiter_if #(.W(8)) bi1 ();

  shiftreg_tx_arbiter #(.W(8), .DIV(4), .GAP(2)) dut0 (.clk(clk), .rst(rst), .bus(bi0));
  shiftreg_tx_arbiter #(.W(8), .DIV(1), .GAP(0)) dut1 (.clk(clk), .rst(rst), .bus(bi1));

  function automatic snap_t get(input int id);
    snap_t s;
    if (id == 0) s = '{bi0.req0_ready, bi0.req1_ready, bi0.sh_out, bi0.sh_en,
                       bi0.sh_frame, bi0.grant, bi0.busy, bi0.done};
    else         s = '{bi1.req0_ready, bi1.req1_ready, bi1.sh_out, bi1.sh_en,
                       bi1.sh_frame, bi1.grant, bi1.busy, bi1.done};
    return s;
  endfunction

  function automatic exp_t mk(input int g, input logic [7:0] d, input bit gc, input int ab);
    exp_t e;
    e.grant = g; e.data = d; e.gapchk = gc; e.abort_at = ab;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic inv(input int id, input snap_t s);
    chk($sformatf("d%0d_ready_onehot", id), 32'(s.r0 & s.r1), 0);
    chk($sformatf("d%0d_en_in_frame", id), 32'(s.en & ~s.frame), 0);
  endtask

  task automatic mon(input int id, input int div, input int gap);
    snap_t s;
    exp_t  e;
    logic  pr0 = 1'b0, pr1 = 1'b0;
    int    idle = 0;
    bit    ab;
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      s = get(id);
      inv(id, s);
      if (s.frame !== 1'b1) begin
        chk($sformatf("d%0d_done_idle", id), 32'(s.done), 0);
        idle++;
        pr0 = s.r0; pr1 = s.r1;
      end else begin
        if ((id == 0 ? q0.size() : q1.size()) == 0) begin
          n_vec++; n_fail++;
          $display("FAIL d%0d_unexpected_frame: got frame expected none at %0t", id, $time);
          e = mk(0, 8'h00, 1'b0, 0);
        end else if (id == 0) e = q0.pop_front();
        else                  e = q1.pop_front();
        chk($sformatf("d%0d_grant", id), 32'(s.grant), e.grant);
        chk($sformatf("d%0d_accept_ready", id), 32'(e.grant != 0 ? pr1 : pr0), 1);
        if (e.gapchk) chk($sformatf("d%0d_frame_spacing", id), idle, gap + 1);
        ab = 1'b0;
        for (int c = 0; c < W * div; c++) begin
          if (c > 0) begin
            @(negedge clk);
            s = get(id);
            inv(id, s);
          end
          if (e.abort_at != 0 && c == e.abort_at) begin
            chk($sformatf("d%0d_abort_frame", id), 32'(s.frame), 0);
            chk($sformatf("d%0d_abort_busy", id), 32'(s.busy), 0);
            chk($sformatf("d%0d_abort_done", id), 32'(s.done), 0);
            ab = 1'b1;
            break;
          end
          chk($sformatf("d%0d_frame_c%0d", id, c), 32'(s.frame), 1);
          chk($sformatf("d%0d_busy_c%0d", id, c), 32'(s.busy), 1);
          chk($sformatf("d%0d_out_c%0d", id, c), 32'(s.out), 32'(e.data[W-1-c/div]));
          chk($sformatf("d%0d_en_c%0d", id, c), 32'(s.en), 32'(c % div == 0));
        end
        if (!ab) begin
          @(negedge clk);
          s = get(id);
          inv(id, s);
          chk($sformatf("d%0d_done_pulse", id), 32'(s.done), 1);
          chk($sformatf("d%0d_frame_end", id), 32'(s.frame), 0);
        end
        idle = ab ? 0 : 1;
        pr0 = s.r0; pr1 = s.r1;
      end
    end
  endtask

  initial mon(0, 4, 2);
  initial mon(1, 1, 0);

  task automatic wait_acc(input int id);
    snap_t s;
    int t = 0;
    do begin
      @(negedge clk);
      s = get(id);
      t++;
    end while (!(s.r0 || s.r1) && t < 500);
    if (!(s.r0 || s.r1)) begin
      n_vec++; n_fail++;
      $display("FAIL d%0d_accept_timeout: got no ready expected ready within 500 cycles", id);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int id);
    snap_t s;
    int t = 0;
    bit ok = 1'b0;
    while (!ok && t < 2000) begin
      @(negedge clk);
      s = get(id);
      t++;
      ok = ((id == 0 ? q0.size() : q1.size()) == 0) && !s.busy && !s.done;
    end
    if (!ok) begin
      n_vec++; n_fail++;
      $display("FAIL d%0d_idle_timeout: got busy expected idle within 2000 cycles", id);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    snap_t s;
    int t;
    bi0.req0_valid = 1'b0; bi0.req0_data = '0; bi0.req1_valid = 1'b0; bi0.req1_data = '0;
    bi1.req0_valid = 1'b0; bi1.req0_data = '0; bi1.req1_valid = 1'b0; bi1.req1_data = '0;

    // Reset with both requesters asserting
    @(posedge clk); #1;
    bi0.req0_valid = 1'b1; bi0.req0_data = 8'h11;
    bi0.req1_valid = 1'b1; bi0.req1_data = 8'h22;
    repeat (5) begin
      @(negedge clk);
      s = get(0);
      chk("rst_readys", {30'd0, s.r0, s.r1}, 0);
      chk("rst_outputs", {27'd0, s.out, s.en, s.frame, s.done, s.busy}, 0);
      chk("rst_grant", 32'(s.grant), 0);
    end
    @(posedge clk); #1;
    bi0.req0_valid = 1'b0; bi0.req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word from requester 0, data changed after acceptance
    q0.push_back(mk(0, 8'hA5, 1'b0, 0));
    bi0.req0_valid = 1'b1; bi0.req0_data = 8'hA5;
    wait_acc(0);
    bi0.req0_valid = 1'b0; bi0.req0_data = 8'h00;
    wait_idle(0);

    // Requester 1 alone, three back-to-back words
    q0.push_back(mk(1, 8'h01, 1'b0, 0));
    q0.push_back(mk(1, 8'h80, 1'b1, 0));
    q0.push_back(mk(1, 8'hFF, 1'b1, 0));
    bi0.req1_valid = 1'b1; bi0.req1_data = 8'h01;
    wait_acc(0);
    bi0.req1_data = 8'h80;
    wait_acc(0);
    bi0.req1_data = 8'hFF;
    wait_acc(0);
    bi0.req1_valid = 1'b0;
    wait_idle(0);

    // Both requesters continuously valid: alternation starting with 0
    q0.push_back(mk(0, 8'h0F, 1'b0, 0));
    q0.push_back(mk(1, 8'hF0, 1'b1, 0));
    q0.push_back(mk(0, 8'h0F, 1'b1, 0));
    q0.push_back(mk(1, 8'hF0, 1'b1, 0));
    bi0.req0_valid = 1'b1; bi0.req0_data = 8'h0F;
    bi0.req1_valid = 1'b1; bi0.req1_data = 8'hF0;
    repeat (4) wait_acc(0);
    bi0.req0_valid = 1'b0; bi0.req1_valid = 1'b0;
    wait_idle(0);

    // Reset at frame cycle 10 aborts; afterwards req0 wins contention
    q0.push_back(mk(0, 8'h3C, 1'b0, 11));
    q0.push_back(mk(0, 8'h55, 1'b0, 0));
    q0.push_back(mk(1, 8'hAA, 1'b1, 0));
    bi0.req0_valid = 1'b1; bi0.req0_data = 8'h3C;
    wait_acc(0);
    bi0.req0_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      s = get(0);
      t++;
    end while (s.frame !== 1'b1 && t < 50);
    chk("abort_frame_started", 32'(s.frame), 1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    bi0.req0_valid = 1'b1; bi0.req0_data = 8'h55;
    bi0.req1_valid = 1'b1; bi0.req1_data = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    s = get(0);
    chk("rst_idle_readys", {30'd0, s.r0, s.r1}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) wait_acc(0);
    bi0.req0_valid = 1'b0; bi0.req1_valid = 1'b0;
    wait_idle(0);

    // DIV=1, GAP=0 build, requester 0 held valid
    q1.push_back(mk(0, 8'hC3, 1'b0, 0));
    q1.push_back(mk(0, 8'h5A, 1'b1, 0));
    q1.push_back(mk(0, 8'h96, 1'b1, 0));
    bi1.req0_valid = 1'b1; bi1.req0_data = 8'hC3;
    wait_acc(1);
    bi1.req0_data = 8'h5A;
    wait_acc(1);
    bi1.req0_data = 8'h96;
    wait_acc(1);
    bi1.req0_valid = 1'b0;
    wait_idle(1);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
